mar_burst: RTL and testbench
============================

# mar_burst

Parametrised memory address register with burst sequencing for the 16-bit CPU datapath. It sits between the control unit and data memory, where the single-shot address register used to sit. It keeps the legacy single-address load (`en_mar`) and adds a burst mode: from a base address it steps by a fixed stride, once per accepted beat, under a `mem_ready` handshake. Used for block moves and multi-word loads/stores without control-unit sequencing.

## Interface
Parameters:
- `ADDR_W`, 8: address width in bits.
- `LEN_W`, 4: width of the beat-count field; max burst is 2^LEN_W beats.
- `STRIDE`, 1: address step per beat (unsigned, < 2^ADDR_W).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `en_mar` in 1: single load of `addr_in`. Honoured only in IDLE.
- `addr_in` in ADDR_W: base or single address.
- `burst_start` in 1: start a burst at `addr_in`. Honoured only in IDLE.
- `burst_len` in LEN_W: beats minus one (0 means 1 beat), sampled with `burst_start`.
- `dir` in 1: 0 increments, 1 decrements. Sampled with `burst_start`.
- `burst_abort` in 1: terminate the burst. Honoured only in BURST.
- `mem_ready` in 1: memory accepts the current beat.
- `addr_out` out ADDR_W: registered address to memory.
- `addr_valid` out 1: a burst beat is presented. High exactly while in BURST.
- `busy` out 1: equals `addr_valid`, kept separate for the control unit.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `wrap` out 1: one-cycle pulse when a step crosses the address space boundary.

## Operation
- States are IDLE and BURST. All outputs are registered.
- Reset (`rst`=1 at an edge) wins over everything: `addr_out`=0, `addr_valid`=0, `busy`=0, `done`=0, `wrap`=0, beat counter=0, state IDLE. A reset during a burst drops it silently, with no `done`.
- IDLE, priority `burst_start` > `en_mar`:
  - `burst_start`: `addr_out`<=`addr_in`, counter<=`burst_len`, latch `dir`, go to BURST.
  - `en_mar` alone: `addr_out`<=`addr_in`; state and flags are unchanged. This is the legacy behaviour.
  - Neither: hold.
- BURST; `en_mar` and `burst_start` are ignored here:
  - `burst_abort`: go to IDLE next edge. `addr_out` holds, no `done`. Abort takes priority over `mem_ready` in the same cycle.
  - `mem_ready`=1 and counter==0: go to IDLE. `done`<=1 for one cycle. `addr_out` holds the last beat address.
  - `mem_ready`=1 and counter>0: `addr_out`<=`addr_out`±STRIDE modulo 2^ADDR_W, counter<=counter−1.
  - `mem_ready`=0: hold everything.
- `wrap` is registered with the stepped address:
  - It is 1 when an increment produces a carry out of ADDR_W bits, or a decrement produces a borrow.
  - It is 0 in every other cycle.
- The counter is LEN_W bits, decrements only, and never underflows.

## Timing
- Single load: `addr_out` updates 1 cycle after `en_mar`.
- Burst: the first beat address and `addr_valid` appear 1 cycle after `burst_start`.
- With `mem_ready` held high, one beat is issued per cycle, so a burst of N beats occupies N cycles of `addr_valid`.
- A beat completes when `addr_valid` and `mem_ready` are both high at a rising edge.
- `done` is high in the first IDLE cycle, the same cycle that `addr_valid` and `busy` fall.
- A new `burst_start` is accepted in that same cycle, so back-to-back bursts have 1 idle cycle between them.

## Structure
- The shared CPU package holds:
  - the state enum (IDLE, BURST);
  - a default-width constant matching the CPU address bus.
- One natural sub-module, `mar_beat_counter`: a loadable down-counter of LEN_W bits with a `last` (==0) flag and a decrement enable.
- The stepper (add/subtract STRIDE plus carry/borrow extraction) stays inline.

## Test plan
Use ADDR_W=8, LEN_W=4, STRIDE=1 unless stated otherwise.
- Reset: drive random inputs, then `rst`=1 for 1 cycle -> all outputs 0, state IDLE. Repeat with `rst` asserted mid-burst -> burst dropped, no `done`.
- Single load: `en_mar`=1, `addr_in`=0x3C -> `addr_out`=0x3C next cycle, `addr_valid`=0, `busy`=0. Assert `en_mar` and `burst_start` together -> the burst starts.
- Increment burst: `addr_in`=0x10, `burst_len`=3, `dir`=0, `mem_ready`=1 -> `addr_out` is 0x10, 0x11, 0x12, 0x13 on 4 consecutive valid cycles, then `done` for 1 cycle with `busy`=0.
- Wrap and decrement:
  - `addr_in`=0xFE, `burst_len`=2, `dir`=0 -> 0xFE, 0xFF, 0x00, with `wrap` high with 0x00 only.
  - `addr_in`=0x01, `burst_len`=2, `dir`=1 -> 0x01, 0x00, 0xFF, with `wrap` high with 0xFF.
- Backpressure and interference: burst at 0x40 with `burst_len`=2 and `mem_ready` pattern 1,0,0,1,1 -> 0x40, 0x41, 0x41, 0x41, 0x42, then `done`. Pulse `en_mar` with `addr_in`=0x99 mid-burst -> ignored.
- Abort: burst at 0x20 with `burst_len`=7; assert `burst_abort` with `mem_ready`=1 while at 0x22 -> IDLE next cycle, `addr_out`=0x22, `done` never asserted. Repeat with STRIDE=4 -> steps of 4.

Source files
------------

// File: rtl/mar_pkg.sv
// mar_pkg: definitions shared by the CPU datapath blocks around the memory
// address register.
//   mar_state_e           : burst sequencer states (IDLE, BURST)
//   MAR_DEFAULT_ADDR_W    : default width of the data-memory address bus
package mar_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } mar_state_e;

   localparam int MAR_DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/mar_beat_counter.sv
// mar_beat_counter: loadable LEN_W-bit down-counter of the beats remaining in
// a burst.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (takes priority over dec)
//   load_val  : beats minus one
//   dec       : decrement enable; ignored at zero so the count never wraps
//   count     : current count
//   last      : count is zero, i.e. the current beat is the final one
module mar_beat_counter #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] load_val,
   input  logic             dec,
   output logic [LEN_W-1:0] count,
   output logic             last
);

   logic [LEN_W-1:0] count_q;
   logic [LEN_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign last  = (count_q == '0);

endmodule

// File: rtl/mar_burst.sv
// mar_burst: memory address register with burst sequencing.
//   clk, rst        : clock, synchronous active-high reset
//   en_mar, addr_in : legacy single-address load (IDLE only)
//   burst_start     : start a burst at addr_in (IDLE only, wins over en_mar)
//   burst_len, dir  : beats minus one and direction (1 = decrement), sampled
//                     with burst_start
//   burst_abort     : drop the current burst without done (BURST only)
//   mem_ready       : memory accepts the presented beat
//   addr_out        : registered address to memory
//   addr_valid/busy : high exactly while a burst is in progress
//   done            : one-cycle pulse after the final beat is accepted
//   wrap            : one-cycle pulse with a step that crossed the address
//                     space boundary
module mar_burst
   import mar_pkg::*;
#(
   parameter int ADDR_W = MAR_DEFAULT_ADDR_W,
   parameter int LEN_W  = 4,
   parameter int STRIDE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_mar,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              burst_start,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              dir,
   input  logic              burst_abort,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] addr_out,
   output logic              addr_valid,
   output logic              busy,
   output logic              done,
   output logic              wrap
);

   // One extra bit so the carry/borrow of the step lands in the MSB.
   localparam logic [ADDR_W:0] STRIDE_X = (ADDR_W + 1)'(STRIDE);

   mar_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              dir_q, dir_d;
   logic              valid_q, busy_q;
   logic              done_q, done_d;
   logic              wrap_q, wrap_d;

   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_last;
   logic [LEN_W-1:0]  cnt_value;

   logic [ADDR_W:0]   step_sum;
   logic [ADDR_W:0]   step_diff;

   mar_beat_counter #(
      .LEN_W (LEN_W)
   ) u_beat_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (burst_len),
      .dec      (cnt_dec),
      .count    (cnt_value),
      .last     (cnt_last)
   );

   // Stepper: bit ADDR_W of the sum is the carry; of the difference it is the
   // borrow (set exactly when addr_q < STRIDE).
   assign step_sum  = {1'b0, addr_q} + STRIDE_X;
   assign step_diff = {1'b0, addr_q} - STRIDE_X;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      wrap_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (burst_start) begin
               addr_d   = addr_in;
               dir_d    = dir;
               cnt_load = 1'b1;
               state_d  = ST_BURST;
            end else if (en_mar) begin
               addr_d = addr_in;
            end
         end
         ST_BURST: begin
            if (burst_abort) begin
               state_d = ST_IDLE;
            end else if (mem_ready) begin
               if (cnt_last) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
                  if (dir_q) begin
                     addr_d = step_diff[ADDR_W-1:0];
                     wrap_d = step_diff[ADDR_W];
                  end else begin
                     addr_d = step_sum[ADDR_W-1:0];
                     wrap_d = step_sum[ADDR_W];
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         dir_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         dir_q   <= dir_d;
         // Flags registered from the next state so they track state_q exactly.
         valid_q <= (state_d == ST_BURST);
         busy_q  <= (state_d == ST_BURST);
         done_q  <= done_d;
         wrap_q  <= wrap_d;
      end
   end

   assign addr_out   = addr_q;
   assign addr_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign wrap       = wrap_q;

   // The counter's raw value is only needed through its last flag.
   logic unused_ok;
   assign unused_ok = ^cnt_value;

endmodule

// File: tb/tb_mar_burst.sv
// tb_mar_burst: scoreboard bench. Two instances (STRIDE=1 and STRIDE=4) share
// one stimulus stream; a behavioural model predicts every cycle's outputs of
// both, the driver queues them, and a monitor pops and compares after each
// rising edge.
module tb_mar_burst;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_mar = 1'b0;
   logic [7:0] addr_in = '0;
   logic       burst_start = 1'b0;
   logic [3:0] burst_len = '0;
   logic       dir = 1'b0;
   logic       burst_abort = 1'b0;
   logic       mem_ready = 1'b0;

   logic [7:0] a1, a4;
   logic       v1, v4, b1, b4, d1, d4, w1, w4;

   always #5 clk = ~clk;

   mar_burst #(.ADDR_W(8), .LEN_W(4), .STRIDE(1)) dut1 (
      .clk(clk), .rst(rst), .en_mar(en_mar), .addr_in(addr_in),
      .burst_start(burst_start), .burst_len(burst_len), .dir(dir),
      .burst_abort(burst_abort), .mem_ready(mem_ready),
      .addr_out(a1), .addr_valid(v1), .busy(b1), .done(d1), .wrap(w1));

   mar_burst #(.ADDR_W(8), .LEN_W(4), .STRIDE(4)) dut4 (
      .clk(clk), .rst(rst), .en_mar(en_mar), .addr_in(addr_in),
      .burst_start(burst_start), .burst_len(burst_len), .dir(dir),
      .burst_abort(burst_abort), .mem_ready(mem_ready),
      .addr_out(a4), .addr_valid(v4), .busy(b4), .done(d4), .wrap(w4));

   // Model: a burst is a base address, a beat index and a length; the beat
   // address is base +/- index*stride taken modulo 256.
   typedef struct {
      bit in_burst;
      int base;
      int idx;
      int len;
      bit dir;
      int addr;
      bit done;
      bit wrap;
   } model_t;

   typedef struct {
      int a1, a4;
      bit v1, v4, d1, d4, w1, w4;
   } exp_t;

   model_t m1, m4;
   exp_t   sb_q[$];
   int     total = 0;
   int     bad = 0;
   int     cycle = 0;

   function automatic int beat_raw(model_t m, int s, int i);
      return m.dir ? (m.base - i * s) : (m.base + i * s);
   endfunction

   function automatic model_t model_step(model_t m, int s);
      model_t n;
      int raw, prev;
      n = m;
      n.done = 1'b0;
      n.wrap = 1'b0;
      if (rst) begin
         n.in_burst = 0; n.base = 0; n.idx = 0; n.len = 0;
         n.dir = 0; n.addr = 0;
      end else if (!m.in_burst) begin
         if (burst_start) begin
            n.in_burst = 1; n.base = int'(addr_in); n.idx = 0;
            n.len = int'(burst_len); n.dir = dir; n.addr = int'(addr_in);
         end else if (en_mar) begin
            n.addr = int'(addr_in);
         end
      end else if (burst_abort) begin
         n.in_burst = 0;
      end else if (mem_ready) begin
         if (m.idx == m.len) begin
            n.in_burst = 0;
            n.done = 1'b1;
         end else begin
            n.idx  = m.idx + 1;
            raw    = beat_raw(n, s, n.idx);
            prev   = beat_raw(n, s, m.idx);
            n.addr = raw & 255;
            // Crossing a multiple of 256 (either way) is a wrap.
            n.wrap = ((raw >>> 8) != (prev >>> 8));
         end
      end
      return n;
   endfunction

   task automatic tick();
      exp_t e;
      m1 = model_step(m1, 1);
      m4 = model_step(m4, 4);
      e.a1 = m1.addr; e.v1 = m1.in_burst; e.d1 = m1.done; e.w1 = m1.wrap;
      e.a4 = m4.addr; e.v4 = m4.in_burst; e.d4 = m4.done; e.w4 = m4.wrap;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc(input bit bs, input bit en, input int ain, input int len,
                      input bit dr, input bit ab, input bit rdy);
      burst_start = bs;
      en_mar      = en;
      addr_in     = 8'(ain);
      burst_len   = 4'(len);
      dir         = dr;
      burst_abort = ab;
      mem_ready   = rdy;
      tick();
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cycle, act, exp_v);
      end
   endtask

   // Monitor: one comparison set per presented output cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("s1_addr_out", int'(a1), e.a1);
            chk("s1_addr_valid", int'(v1), int'(e.v1));
            chk("s1_busy", int'(b1), int'(e.v1));
            chk("s1_done", int'(d1), int'(e.d1));
            chk("s1_wrap", int'(w1), int'(e.w1));
            chk("s4_addr_out", int'(a4), e.a4);
            chk("s4_addr_valid", int'(v4), int'(e.v4));
            chk("s4_busy", int'(b4), int'(e.v4));
            chk("s4_done", int'(d4), int'(e.d4));
            chk("s4_wrap", int'(w4), int'(e.w4));
            $display("cyc %0d a1=%02h v1=%0b d1=%0b w1=%0b a4=%02h v4=%0b d4=%0b w4=%0b",
                     cycle, a1, v1, d1, w1, a4, v4, d4, w4);
         end
      end
   end

   initial begin
      int guard;
      m1 = '{default: 0};
      m4 = '{default: 0};

      // Reset with random inputs present.
      rst = 1'b1;
      cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 255),
          $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1));
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Single load, then en_mar together with burst_start.
      cyc(0, 1, 8'h3C, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 8'h50, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Increment burst 0x10..0x13.
      cyc(1, 0, 8'h10, 3, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Wrap on increment and on decrement, back to back.
      cyc(1, 0, 8'hFE, 2, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 8'h01, 2, 1, 0, 1);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Backpressure 1,0,0,1,1 with an en_mar pulse mid-burst.
      cyc(1, 0, 8'h40, 2, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 1, 8'h99, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Abort at the third beat with mem_ready also high.
      cyc(1, 0, 8'h20, 7, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Reset mid-burst: dropped without done.
      cyc(1, 0, 8'h70, 9, 1, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 79) == 0);
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 255), $urandom_range(0, 15),
             $urandom_range(0, 1), $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) < 7);
      end
      rst = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0);

      guard = 0;
      while (sb_q.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
